// File: rtl/irq_req_ctrl_pkg.sv
// Shared types and constants for the interrupt request capture/presentation slice.
package irq_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   req_idx_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;
endpackage

// File: rtl/irq_req_ctrl_if.sv
// Request, mask, overrun and valid/ack presentation signals of irq_req_ctrl.
interface irq_req_ctrl_if;
  import irq_pkg::*;

  req_vec_t req_i;
  logic     mask_we_i;
  req_vec_t mask_wdata_i;
  logic     ovr_clr_i;
  logic     irq_ack_i;
  logic     irq_valid_o;
  req_idx_t irq_id_o;
  req_vec_t pend_o;
  req_vec_t mask_o;
  req_vec_t ovr_o;

  modport master (
    output req_i, mask_we_i, mask_wdata_i, ovr_clr_i, irq_ack_i,
    input  irq_valid_o, irq_id_o, pend_o, mask_o, ovr_o
  );

  modport slave (
    input  req_i, mask_we_i, mask_wdata_i, ovr_clr_i, irq_ack_i,
    output irq_valid_o, irq_id_o, pend_o, mask_o, ovr_o
  );
endinterface

// File: rtl/irq_req_ctrl_prio_sel.sv
// Combinational 8-to-3 highest-set-bit selector; a zero vector yields idx = 0, any = 0.
module irq_prio_sel
  import irq_pkg::*;
(
  input  req_vec_t vec,
  output req_idx_t idx,
  output logic     any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i]) idx = req_idx_t'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/irq_req_ctrl.sv
// Latches request lines into a pending register, masks them and presents the
// highest-priority pending index on a valid/ack handshake.
//   state   | meaning
//   IDLE    | no request presented; evaluates eligible pending bits each cycle
//   PRESENT | irq_id/irq_valid held stable until the consumer acks
module irq_req_ctrl
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  irq_req_ctrl_if.slave  bus
);

  req_vec_t   req_q;
  req_vec_t   pend;
  req_vec_t   mask;
  req_vec_t   ovr;
  req_vec_t   set_v;
  req_vec_t   clr_v;
  req_vec_t   ovr_new;
  req_vec_t   eligible;
  req_idx_t   sel_idx;
  logic       sel_any;
  req_idx_t   irq_id;
  logic       irq_valid;
  irq_state_e state;

  assign set_v = EDGE_MODE ? (bus.req_i & ~req_q) : bus.req_i;

  // Only an ack against a live presentation clears anything.
  always_comb begin
    clr_v = '0;
    if ((state == PRESENT) && irq_valid && bus.irq_ack_i) clr_v[irq_id] = 1'b1;
  end

  assign ovr_new  = set_v & pend & ~clr_v;
  assign eligible = pend & ~mask;

  irq_prio_sel u_prio_sel (
    .vec (eligible),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      pend  <= '0;
      mask  <= '0;
      ovr   <= '0;
    end else begin
      req_q <= bus.req_i;
      pend  <= (pend & ~clr_v) | set_v;
      ovr   <= (bus.ovr_clr_i ? '0 : ovr) | ovr_new;
      if (bus.mask_we_i) mask <= bus.mask_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      irq_id    <= '0;
      irq_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            irq_id    <= sel_idx;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.irq_ack_i) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irq_valid_o = irq_valid;
  assign bus.irq_id_o    = irq_id;
  assign bus.pend_o      = pend;
  assign bus.mask_o      = mask;
  assign bus.ovr_o       = ovr;

endmodule
